// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

   typedef enum logic [2:0] {
      HEADER = 3'd0,
      LOAD   = 3'd1,
      WRITE  = 3'd2,
      RUN    = 3'd3,
      ERROR  = 3'd4
   } state_t;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_W         = 32;

   // Bytes arrive MSB first, so each new byte enters at the bottom.
   function automatic logic [WORD_W-1:0] pack_byte(input logic [WORD_W-1:0] word,
                                                   input logic [7:0]        data);
      return {word[WORD_W-9:0], data};
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Four-byte shift register that assembles one instruction word, with byte counter.
module byte_packer
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              shift_en,
   input  logic              clear,
   input  logic [7:0]        data,
   output logic [WORD_W-1:0] word,
   output logic              full
);

   logic [1:0] cnt;

   // Asserted while the next shift completes a word.
   assign full = (cnt == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word <= '0;
         cnt  <= '0;
      end else if (clear) begin
         word <= '0;
         cnt  <= '0;
      end else if (shift_en) begin
         word <= pack_byte(word, data);
         cnt  <= cnt + 2'd1;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed byte image into instruction memory, holding the CPU in reset until done.
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [WORD_W-1:0]     imem_wdata,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] word_cnt;
   logic [7:0]       n_words;
   logic             xfer;
   logic             pk_shift;
   logic             pk_clear;
   logic             pk_full;

   assign xfer = in_valid & in_ready;

   // The packer's word register doubles as the registered write-data output.
   byte_packer u_packer (
      .clk      (clk),
      .reset    (reset),
      .shift_en (pk_shift),
      .clear    (pk_clear),
      .data     (in_data),
      .word     (imem_wdata),
      .full     (pk_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= HEADER;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      pk_shift   = 1'b0;
      pk_clear   = 1'b0;
      case (state)
         HEADER: begin
            if (xfer) begin
               pk_clear = 1'b1;
               if (in_data == 8'd0)          state_next = RUN;
               else if (32'(in_data) > DEPTH) state_next = ERROR;
               else                          state_next = LOAD;
            end
         end
         LOAD: begin
            if (xfer) begin
               pk_shift = 1'b1;
               if (pk_full) state_next = WRITE;
            end
         end
         WRITE: begin
            if (32'(word_cnt) + 32'd1 == 32'(n_words)) state_next = RUN;
            else                                      state_next = LOAD;
         end
         RUN, ERROR: begin
            if (load_start) state_next = HEADER;
         end
         default: state_next = HEADER;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_cnt  <= '0;
         n_words   <= '0;
         in_ready  <= 1'b0;
         imem_we   <= 1'b0;
         imem_addr <= '0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         in_ready  <= (state_next == HEADER) || (state_next == LOAD);
         imem_we   <= (state_next == WRITE);
         cpu_reset <= (state_next != RUN);
         done      <= (state_next == RUN);
         error     <= (state_next == ERROR);
         if (state == HEADER && xfer) begin
            n_words  <= in_data;
            word_cnt <= '0;
         end
         if (state == WRITE) word_cnt <= word_cnt + CNT_W'(1);
         if (state_next == WRITE) imem_addr <= word_cnt[ADDR_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed/randomized bench for program_loader against a queue-based write model.
module tb_program_loader;

   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_reset;
   logic          done;
   logic          error;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t wq[$];
   wr_t eq[$];

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   int rdy_bad = 0;
   bit track   = 1'b0;

   program_loader #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .error      (error)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (imem_we === 1'b1) wq.push_back('{addr: int'(imem_addr), data: imem_wdata});
      if (track && !done && !error && (in_ready !== ~imem_we)) rdy_bad++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"},  32'(in_ready),  32'd0);
      check({tag, "_imem_we"},   32'(imem_we),   32'd0);
      check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
      check({tag, "_imem_wdata"}, imem_wdata,    32'd0);
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
      check({tag, "_done"},      32'(done),      32'd0);
      check({tag, "_error"},     32'(error),     32'd0);
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_wr_count"}, 32'(wq.size()), 32'(eq.size()));
      for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), 32'(wq[i].addr), 32'(eq[i].addr));
         check($sformatf("%s_data%0d", tag, i), wq[i].data, eq[i].data);
      end
      wq.delete();
      eq.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int g;
      bit acc;
      g   = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      acc = 1'b0;
      repeat (g) begin
         @(negedge clk) in_valid = 1'b0;
         @(posedge clk);
      end
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = b;
         acc      = in_ready;
         @(posedge clk);
      end
      #1 in_valid = 1'b0;
      if (!acc) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic load_word(input logic [31:0] w, input int maxgap);
      logic [7:0] b;
      for (int k = 0; k < 4; k++) begin
         b = 8'((w >> (24 - 8 * k)) & 32'hFF);
         send_byte(b, maxgap);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) load_start = 1'b1;
      @(posedge clk);
      #1 load_start = 1'b0;
   endtask

   task automatic full_load(input string tag, input int n, input int maxgap);
      logic [31:0] w;
      int t0;
      send_byte(8'(n), 0);
      t0 = cyc;
      for (int i = 0; i < n; i++) begin
         w = $urandom();
         eq.push_back('{addr: i, data: w});
         load_word(w, maxgap);
      end
      @(negedge clk);
      check({tag, "_last_we"},    32'(imem_we),   32'd1);
      check({tag, "_last_addr"},  32'(imem_addr), 32'(n - 1));
      check({tag, "_last_data"},  imem_wdata,     w);
      check({tag, "_wr_cpurst"},  32'(cpu_reset), 32'd1);
      check({tag, "_wr_ready"},   32'(in_ready),  32'd0);
      @(negedge clk);
      check({tag, "_we_off"},     32'(imem_we),   32'd0);
      check({tag, "_cpu_rel"},    32'(cpu_reset), 32'd0);
      check({tag, "_done"},       32'(done),      32'd1);
      if (maxgap == 0) check({tag, "_cycles"}, 32'(cyc - t0), 32'(5 * n));
      check_writes(tag);
   endtask

   initial begin
      logic [31:0] w;
      int          seen;

      reset      = 1'b0;
      load_start = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;

      #12 check_idle("rst");
      @(negedge clk) reset = 1'b1;
      #1 check("rst_ready_hold", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 check("rst_ready_up", 32'(in_ready), 32'd1);

      // Empty program goes straight to RUN.
      send_byte(8'd0, 0);
      @(negedge clk);
      check("n0_done",   32'(done),      32'd1);
      check("n0_cpurst", 32'(cpu_reset), 32'd0);
      check("n0_ready",  32'(in_ready),  32'd0);
      check_writes("n0");

      pulse_start();
      @(negedge clk);
      check("hdr_cpurst", 32'(cpu_reset), 32'd1);
      check("hdr_done",   32'(done),      32'd0);
      check("hdr_ready",  32'(in_ready),  32'd1);

      full_load("l6", 6, 0);

      // Reload from RUN; a load_start mid-load must be ignored.
      pulse_start();
      send_byte(8'd2, 0);
      w = $urandom();
      eq.push_back('{addr: 0, data: w});
      load_word(w, 0);
      @(negedge clk);
      check("l2_cpurst_mid", 32'(cpu_reset), 32'd1);
      check("l2_done_mid",   32'(done),      32'd0);
      pulse_start();
      @(negedge clk);
      check("l2_ignore_start", 32'(in_ready), 32'd1);
      w = $urandom();
      eq.push_back('{addr: 1, data: w});
      load_word(w, 0);
      @(negedge clk);
      check("l2_addr1", 32'(imem_addr), 32'd1);
      @(negedge clk);
      check("l2_done",   32'(done),      32'd1);
      check("l2_cpurst", 32'(cpu_reset), 32'd0);
      check_writes("l2");

      // Random stalls on in_valid.
      pulse_start();
      send_byte(8'd3, 0);
      track = 1'b1;
      eq.push_back('{addr: 0, data: 32'h12345678});
      load_word(32'h12345678, 3);
      for (int i = 1; i < 3; i++) begin
         w = $urandom();
         eq.push_back('{addr: i, data: w});
         load_word(w, 3);
      end
      repeat (2) @(negedge clk);
      track = 1'b0;
      check("gap_done", 32'(done), 32'd1);
      check("gap_ready_vs_write", 32'(rdy_bad), 32'd0);
      check_writes("gap");

      pulse_start();
      full_load("l64", int'(DEPTH), 0);

      // Oversized header.
      pulse_start();
      send_byte(8'(DEPTH + 1), 0);
      @(negedge clk);
      check("err_flag",   32'(error),     32'd1);
      check("err_ready",  32'(in_ready),  32'd0);
      check("err_cpurst", 32'(cpu_reset), 32'd1);
      check("err_done",   32'(done),      32'd0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'hAA;
         if (in_ready) seen++;
         @(posedge clk);
      end
      #1 in_valid = 1'b0;
      check("err_no_accept", 32'(seen), 32'd0);
      check("err_hold", 32'(error), 32'd1);
      check_writes("err");
      pulse_start();
      @(negedge clk);
      check("err_clear",       32'(error),     32'd0);
      check("err_hdr_ready",   32'(in_ready),  32'd1);
      check("err_hdr_cpurst",  32'(cpu_reset), 32'd1);

      // Reset in the middle of word 1.
      send_byte(8'd3, 0);
      w = $urandom();
      eq.push_back('{addr: 0, data: w});
      load_word(w, 0);
      send_byte(8'hC3, 0);
      send_byte(8'h5A, 0);
      @(negedge clk) reset = 1'b0;
      #1 check_idle("midrst");
      check_writes("midrst");
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      full_load("fresh1", 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
